// File: rtl/sd_bram_pkg.sv
// Shared types and widths for the SD host controller register-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sd_bram_pkg;

  localparam int BramAddrWidth = 6;
  localparam int BramDataWidth = 32;
  localparam int BramMaskWidth = BramDataWidth / 8;

  // One downstream access as seen on the register port.
  typedef struct packed {
    logic                     we;
    logic [BramMaskWidth-1:0] wmask;
    logic [BramAddrWidth-1:0] addr;
    logic [BramDataWidth-1:0] wdata;
  } bram_req_t;

endpackage

// File: rtl/sd_bram_arbiter_if.sv
// Bundle of per-host request/response signals plus the downstream register port.
// Latency: n/a (wiring only).
// Backpressure: hosts hold a request until host_gnt_o; no stall on the downstream side.
// Ports: master = hosts + register-port environment, slave = the arbiter.
interface sd_bram_arbiter_if
  import sd_bram_pkg::*;
#(
  parameter int NumHosts  = 2,
  parameter int AddrWidth = BramAddrWidth,
  parameter int DataWidth = BramDataWidth
) ();

  localparam int MaskWidth = DataWidth / 8;

  // Host side
  logic [NumHosts-1:0]                 host_en_i;
  logic [NumHosts-1:0]                 host_we_i;
  logic [NumHosts-1:0][MaskWidth-1:0]  host_wmask_i;
  logic [NumHosts-1:0][AddrWidth-1:0]  host_addr_i;
  logic [NumHosts-1:0][DataWidth-1:0]  host_wdata_i;
  logic [NumHosts-1:0]                 host_gnt_o;
  logic [NumHosts-1:0]                 host_rvalid_o;
  logic [DataWidth-1:0]                host_rdata_o;

  // Downstream register port
  logic                                bram_en_o;
  logic                                bram_we_o;
  logic [MaskWidth-1:0]                bram_wmask_o;
  logic [AddrWidth-1:0]                bram_addr_o;
  logic [DataWidth-1:0]                bram_wdata_o;
  logic [DataWidth-1:0]                bram_rdata_i;

  modport master (
    output host_en_i, host_we_i, host_wmask_i, host_addr_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o,
    input  bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o,
    output bram_rdata_i
  );

  modport slave (
    input  host_en_i, host_we_i, host_wmask_i, host_addr_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o,
    output bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o,
    input  bram_rdata_i
  );

endinterface

// File: rtl/sd_bram_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer.
// Latency: grant is combinational; pointer advances on the edge after an update.
// Backpressure: a requester simply waits; any requester is served within N cycles.
// Ports: i_clk/i_rst clock and sync reset, i_req request vector, i_update grant-taken
//        strobe, o_gnt one-hot grant, o_idx binary index of the grant.
module rr_arbiter #(
  parameter int  N    = 2,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_req,
  input  logic            i_update,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx
);

  logic [IdxW-1:0] r_ptr;
  logic            w_found;
  int              w_cand;

  // Search upward from r_ptr, wrapping modulo N; first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int i = 0; i < N; i++) begin
      w_cand = (int'(r_ptr) + i) % N;
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = IdxW'(w_cand);
      end
    end
  end

  // Pointer moves just past the host that was served, so it gets lowest priority next.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= (o_idx == IdxW'(N - 1)) ? '0 : o_idx + IdxW'(1);
    end
  end

endmodule

// File: rtl/sd_bram_arbiter.sv
// Shares the SD host controller's single register port between NumHosts requesters.
// Latency: request path is combinational (grant and strobe same cycle); read data
//          returns to the issuing host ReadLatency cycles after its grant.
// Backpressure: hosts hold their request until granted; one access per cycle downstream.
// Ports: clk_i clock, rst_i sync active-high reset, bus = host requests/responses and
//        the downstream register port (slave view of sd_bram_arbiter_if).
module sd_bram_arbiter
  import sd_bram_pkg::*;
#(
  parameter int NumHosts    = 2,
  parameter int AddrWidth   = BramAddrWidth,
  parameter int DataWidth   = BramDataWidth,
  parameter int ReadLatency = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sd_bram_arbiter_if.slave bus
);

  localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;

  if (NumHosts < 2 || NumHosts > 4) begin : g_bad_num_hosts
    $error("sd_bram_arbiter: NumHosts must be in 2..4");
  end
  if (ReadLatency < 1 || ReadLatency > 3) begin : g_bad_read_latency
    $error("sd_bram_arbiter: ReadLatency must be in 1..3");
  end
  if (AddrWidth != BramAddrWidth || DataWidth != BramDataWidth) begin : g_bad_widths
    $error("sd_bram_arbiter: AddrWidth/DataWidth must match the bram_req_t layout");
  end

  logic [NumHosts-1:0] w_req;
  logic [NumHosts-1:0] w_gnt;
  logic [IdxW-1:0]     w_idx;
  logic                w_any;
  logic                w_rd_push;
  logic                w_tail_vld;
  bram_req_t           w_sel;

  // {valid, one-hot host id} shift pipeline matching the downstream read latency.
  logic [ReadLatency-1:0]               r_pipe_vld;
  logic [ReadLatency-1:0][NumHosts-1:0] r_pipe_id;

  // Masking requests during reset keeps grants and the strobe low even with en high.
  assign w_req = bus.host_en_i & {NumHosts{~rst_i}};

  rr_arbiter #(
    .N (NumHosts)
  ) u_rr_arbiter (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_req    (w_req),
    .i_update (w_any),
    .o_gnt    (w_gnt),
    .o_idx    (w_idx)
  );

  assign w_any = |w_gnt;

  always_comb begin
    w_sel = '0;
    if (w_any) begin
      w_sel.we    = bus.host_we_i[w_idx];
      w_sel.wmask = bus.host_we_i[w_idx] ? bus.host_wmask_i[w_idx] : '0;
      w_sel.addr  = bus.host_addr_i[w_idx];
      w_sel.wdata = bus.host_wdata_i[w_idx];
    end
  end

  assign bus.host_gnt_o   = w_gnt;
  assign bus.bram_en_o    = w_any;
  assign bus.bram_we_o    = w_sel.we;
  assign bus.bram_wmask_o = w_sel.wmask;
  assign bus.bram_addr_o  = w_sel.addr;
  assign bus.bram_wdata_o = w_sel.wdata;

  assign w_rd_push = w_any & ~w_sel.we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pipe_vld <= '0;
      r_pipe_id  <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_push;
      r_pipe_id[0]  <= w_rd_push ? w_gnt : '0;
      for (int i = 1; i < ReadLatency; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
      end
    end
  end

  // Gating with rst_i drops a read whose data lands in the first reset cycle.
  assign w_tail_vld        = r_pipe_vld[ReadLatency-1] & ~rst_i;
  assign bus.host_rvalid_o = w_tail_vld ? r_pipe_id[ReadLatency-1] : '0;
  assign bus.host_rdata_o  = w_tail_vld ? bus.bram_rdata_i : '0;

endmodule

// File: tb/tb_sd_bram_arbiter.sv
// Bench for sd_bram_arbiter: three instances (ReadLatency 1, 2, 3) share one host stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_bram_arbiter;

  localparam int NumDut = 3;
  localparam int MaxCyc = 256;

  typedef struct {
    int          due;
    logic [1:0]  host;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  h_en;
  logic [1:0]  h_we;
  logic [3:0]  h_wmask [2];
  logic [5:0]  h_addr  [2];
  logic [31:0] h_wdata [2];

  logic [31:0] rd_drv  [NumDut];
  logic [1:0]  o_gnt   [NumDut];
  logic [1:0]  o_rv    [NumDut];
  logic        o_en    [NumDut];
  logic        o_we    [NumDut];
  logic [3:0]  o_wmask [NumDut];
  logic [5:0]  o_addr  [NumDut];
  logic [31:0] o_wdata [NumDut];
  logic [31:0] o_rdata [NumDut];

  logic [31:0] sched [NumDut][MaxCyc];
  rsp_t        sb0[$];
  rsp_t        sb1[$];
  rsp_t        sb2[$];
  int          cyc;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    sd_bram_arbiter_if #(.NumHosts(2), .AddrWidth(6), .DataWidth(32)) bus ();

    sd_bram_arbiter #(
      .NumHosts    (2),
      .AddrWidth   (6),
      .DataWidth   (32),
      .ReadLatency (g + 1)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );

    assign bus.host_en_i    = h_en;
    assign bus.host_we_i    = h_we;
    assign bus.host_wmask_i = {h_wmask[1], h_wmask[0]};
    assign bus.host_addr_i  = {h_addr[1], h_addr[0]};
    assign bus.host_wdata_i = {h_wdata[1], h_wdata[0]};
    assign bus.bram_rdata_i = rd_drv[g];

    assign o_gnt[g]   = bus.host_gnt_o;
    assign o_rv[g]    = bus.host_rvalid_o;
    assign o_rdata[g] = bus.host_rdata_o;
    assign o_en[g]    = bus.bram_en_o;
    assign o_we[g]    = bus.bram_we_o;
    assign o_wmask[g] = bus.bram_wmask_o;
    assign o_addr[g]  = bus.bram_addr_o;
    assign o_wdata[g] = bus.bram_wdata_o;
  end

  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s lat%0d cyc%0d: observed %h expected %h", tag, d + 1, cyc, got, exp);
    end
  endtask

  task automatic sb_push(input int d, input rsp_t e);
    case (d)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sb_flush();
    sb0.delete();
    sb1.delete();
    sb2.delete();
  endtask

  function automatic int sb_size(input int d);
    case (d)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  // Compare this cycle's read return against the scoreboard head, if it is due now.
  task automatic chk_rsp(input int d);
    rsp_t e;
    bit   have;
    have   = 1'b0;
    e.due  = -1;
    e.host = 2'b00;
    e.data = 32'h0;
    case (d)
      0: if (sb0.size() != 0 && sb0[0].due == cyc) begin e = sb0.pop_front(); have = 1'b1; end
      1: if (sb1.size() != 0 && sb1[0].due == cyc) begin e = sb1.pop_front(); have = 1'b1; end
      default: if (sb2.size() != 0 && sb2[0].due == cyc) begin e = sb2.pop_front(); have = 1'b1; end
    endcase
    chk("rvalid", d, 32'(o_rv[d]), have ? 32'(e.host) : 32'h0);
    chk("rdata",  d, o_rdata[d],   have ? e.data : 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < NumDut; d++) rd_drv[d] = sched[d][cyc];
  endtask

  task automatic req(input int h, input logic we, input logic [3:0] m, input logic [5:0] a,
                     input logic [31:0] wd);
    h_en[h]    = 1'b1;
    h_we[h]    = we;
    h_wmask[h] = m;
    h_addr[h]  = a;
    h_wdata[h] = wd;
  endtask

  // One cycle: expected grant is given; downstream fields are derived from the host
  // request registers; a granted read schedules rd as its returned data.
  task automatic step(input logic [1:0] exp_gnt, input logic [31:0] rd);
    int          k;
    logic        e_we;
    logic [3:0]  e_mask;
    logic [5:0]  e_addr;
    logic [31:0] e_wdata;
    rsp_t        e;
    k       = (exp_gnt == 2'b01) ? 0 : (exp_gnt == 2'b10) ? 1 : -1;
    e_we    = 1'b0;
    e_mask  = 4'h0;
    e_addr  = 6'h0;
    e_wdata = 32'h0;
    if (k >= 0) begin
      e_we    = h_we[k];
      e_mask  = h_we[k] ? h_wmask[k] : 4'h0;
      e_addr  = h_addr[k];
      e_wdata = h_wdata[k];
    end
    @(negedge clk);
    if (rst) sb_flush();
    for (int d = 0; d < NumDut; d++) begin
      chk("gnt",        d, 32'(o_gnt[d]),   32'(exp_gnt));
      chk("bram_en",    d, 32'(o_en[d]),    (k >= 0) ? 32'd1 : 32'd0);
      chk("bram_we",    d, 32'(o_we[d]),    32'(e_we));
      chk("bram_wmask", d, 32'(o_wmask[d]), 32'(e_mask));
      chk("bram_addr",  d, 32'(o_addr[d]),  32'(e_addr));
      chk("bram_wdata", d, o_wdata[d],      e_wdata);
      chk_rsp(d);
      if (k >= 0 && !e_we) begin
        e.due  = cyc + d + 1;
        e.host = exp_gnt;
        e.data = rd;
        sched[d][e.due] = rd;
        sb_push(d, e);
      end
    end
    tick();
    if (k >= 0) h_en[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    h_en   = 2'b00;
    h_we   = 2'b00;
    for (int h = 0; h < 2; h++) begin
      h_wmask[h] = 4'h0;
      h_addr[h]  = 6'h0;
      h_wdata[h] = 32'h0;
    end
    // Background read data is never zero so a missing output mask is visible.
    for (int d = 0; d < NumDut; d++)
      for (int c = 0; c < MaxCyc; c++) sched[d][c] = {8'hA5, 8'(d), 16'(c)};
    for (int d = 0; d < NumDut; d++) rd_drv[d] = sched[d][0];

    // Reset with both hosts requesting: no grant, all outputs zero.
    req(0, 1'b0, 4'hF, 6'h01, 32'h1111_0000);
    req(1, 1'b0, 4'h0, 6'h02, 32'h2222_0000);
    step(2'b00, 32'h0);
    step(2'b00, 32'h0);
    rst = 1'b0;

    // Both hosts reading continuously: strict alternation starting at host 0.
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && i < 5) begin
        if (!h_en[0]) req(0, 1'b0, 4'hF, 6'(8 + i), 32'h1000_0000 + 32'(i));
        if (!h_en[1]) req(1, 1'b0, 4'h3, 6'(16 + i), 32'h2000_0000 + 32'(i));
      end
      step((i % 2 == 0) ? 2'b01 : 2'b10, 32'hC000_0000 + 32'(i));
    end
    idle(4);

    // Host 1 write alone while the pointer is at 0: immediate grant, no response.
    req(1, 1'b1, 4'b0011, 6'h05, 32'h1234_5678);
    step(2'b10, 32'h0);
    // Pointer wrapped back to 0, so host 0 wins the contention.
    req(0, 1'b0, 4'hF, 6'h0C, 32'hAAAA_0000);
    req(1, 1'b0, 4'hF, 6'h0D, 32'hBBBB_0000);
    step(2'b01, 32'h5555_AAAA);
    step(2'b10, 32'h6666_BBBB);
    idle(4);

    // Single host 0 read; read mask must not reach the port.
    req(0, 1'b0, 4'hF, 6'h0A, 32'h0BAD_F00D);
    step(2'b01, 32'hDEAD_BEEF);
    idle(4);

    // Back-to-back reads from different hosts.
    req(0, 1'b0, 4'h0, 6'h21, 32'h0);
    step(2'b01, 32'h0101_0101);
    req(1, 1'b0, 4'h0, 6'h22, 32'h0);
    step(2'b10, 32'h0202_0202);
    idle(4);

    // Reset one cycle after a granted read: the read is dropped, pointer returns to 0.
    req(0, 1'b0, 4'h0, 6'h30, 32'h0);
    step(2'b01, 32'h7777_7777);
    rst = 1'b1;
    req(0, 1'b0, 4'h0, 6'h31, 32'h3131_3131);
    req(1, 1'b0, 4'h0, 6'h32, 32'h3232_3232);
    step(2'b00, 32'h0);
    step(2'b00, 32'h0);
    rst = 1'b0;
    step(2'b01, 32'h8888_0001);
    step(2'b10, 32'h8888_0002);
    idle(4);

    for (int d = 0; d < NumDut; d++) chk("sb_drained", d, 32'(sb_size(d)), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_bram_arbiter.md
Name: sd_bram_arbiter

Overview:
- Round-robin arbiter that shares the single 32-bit BRAM-style register port of the SD host controller between NumHosts requesters, e.g. the TileLink-to-BRAM bridge and a future ADMA descriptor fetcher.
- Sits directly upstream of the SD host controller register port, downstream of the bridges.
- Returns read data to the requester that issued each read, tracking read latency with a pipeline.

Parameters:
- NumHosts, 2, number of requesting ports (2..4).
- AddrWidth, 6, word-address width of the register port.
- DataWidth, 32, data width; mask width is DataWidth/8.
- ReadLatency, 1, cycles from an accepted read on the downstream port to valid bram_rdata_i (1..3).

Ports:
- clk_i  in  1  clock; all logic is on this single clock.
- rst_i  in  1  synchronous, active-high reset.
- host_en_i  in  NumHosts  per-host request valid.
- host_we_i  in  NumHosts  per-host write (1) or read (0).
- host_wmask_i  in  NumHosts x DataWidth/8  per-host byte mask.
- host_addr_i  in  NumHosts x AddrWidth  per-host word address.
- host_wdata_i  in  NumHosts x DataWidth  per-host write data.
- host_gnt_o  out  NumHosts  per-host request accepted this cycle.
- host_rvalid_o  out  NumHosts  per-host read data valid.
- host_rdata_o  out  DataWidth  read data, shared by all hosts and qualified by host_rvalid_o.
- bram_en_o  out  1  downstream access strobe.
- bram_we_o  out  1  downstream write.
- bram_wmask_o  out  DataWidth/8  downstream byte mask.
- bram_addr_o  out  AddrWidth  downstream word address.
- bram_wdata_o  out  DataWidth  downstream write data.
- bram_rdata_i  in  DataWidth  downstream read data, valid ReadLatency cycles after a read strobe.

Behaviour:
- Host handshake:
  - A host holds en/we/wmask/addr/wdata stable until the cycle in which gnt is high.
  - gnt is combinational from the en inputs and the priority pointer.
  - A host may issue its next request in the cycle after gnt.
- Arbitration:
  - Each cycle, at most one host is granted: the first requesting host at or after pointer ptr, searching upward modulo NumHosts.
  - ptr is a register, reset to 0.
  - On a grant to host k, ptr becomes (k+1) mod NumHosts on the next edge.
  - With no requests, ptr holds.
  - Any requesting host is granted within NumHosts cycles.
- Downstream:
  - bram_en_o is high exactly when a grant occurs.
  - bram_we/wmask/addr/wdata come from the granted host through a mux; the path is combinational, adding no latency.
  - When bram_en_o is low, these outputs are driven to 0.
  - When bram_we_o is 0, bram_wmask_o is forced to 0.
- Read return:
  - A shift pipeline of depth ReadLatency carries {valid, one-hot host id}.
  - An entry is pushed every cycle; valid=1 only for granted reads.
  - At the pipeline tail with valid=1, host_rvalid_o[id] is pulsed for one cycle and host_rdata_o = bram_rdata_i passes through combinationally.
  - Otherwise host_rvalid_o is all-zero and host_rdata_o is 0.
- Writes produce no response.
- Back-to-back reads from different hosts in consecutive cycles are supported at full throughput, one access per cycle.
- Reset:
  - Synchronous.
  - ptr=0, pipeline cleared.
  - All outputs are 0 in the cycle after reset asserts and while it is held.
  - Reads in flight when reset asserts are dropped; no rvalid is produced for them.
- While rst_i is high, gnt is forced to 0, even if en is high.
- Simultaneous requests from all hosts: granted strictly in rotation 0,1,..,NumHosts-1 starting at ptr.
- Illegal parameter values (NumHosts<2, ReadLatency<1) must fail elaboration.

Decomposition:
- Package sd_bram_pkg holds:
  - the request struct typedef bram_req_t {we, wmask, addr, wdata}, parameterised through localparams;
  - the localparam BramMaskWidth.
- Sub-module rr_arbiter:
  - Parameterised by N.
  - Inputs: req vector and update strobe.
  - Outputs: one-hot gnt and index.
  - Contains the ptr register.
- Read-return pipeline and muxes stay in the top module.

Test Plan:
- Single host 0 read, addr 6'h0A, bram_rdata_i=32'hDEADBEEF at latency 1 → gnt0 same cycle, bram_en_o=1, bram_addr_o=6'h0A; next cycle host_rvalid_o=2'b01, host_rdata_o=32'hDEADBEEF.
- Both hosts reading continuously from reset → grants alternate 0,1,0,1; rvalid follows the same pattern one cycle later, with the matching rdata each cycle.
- Host 1 write, wmask 4'b0011, wdata 32'h1234_5678 → bram_we_o=1, bram_wmask_o=4'b0011, data forwarded; no rvalid pulse.
- ReadLatency=3: host0 read, then host1 read on consecutive cycles → rvalid 2'b01 at cycle+3, then 2'b10 at cycle+4, each carrying the matching bram_rdata_i.
- Reset asserted one cycle after a granted read (latency 2) → no rvalid ever appears; all outputs 0 during reset; ptr=0 afterwards, so host 0 wins the first contended request.
- Host 1 requesting alone while ptr=0 → granted immediately; ptr becomes 0; host0+host1 contending next cycle → host 0 granted.
